rst_release_seq: RTL and testbench
==================================

Name: rst_release_seq

Overview:
- Reset release sequencer that drives the per-domain reset vector consumed by the clk/rst agent interface (up to 32 domains).
- Takes one master clock and an asynchronous active-low reset.
- Synchronises reset deassertion, holds all domain resets for a programmable time, then releases the domains one at a time in index order with programmable spacing.
- Supports a software-requested re-sequence through a req/ack handshake.

Parameters:
- NUM_RST, 32, number of domain reset outputs; legal range 1..32.
- CNT_W, 16, width of the delay counter and cfg_dly.
- SYNC_STAGES, 2, flops in the reset-deassertion synchroniser; minimum 2.

Ports:
- clk  input  1  master clock; all logic is on its rising edge.
- rst  input  1  asynchronous assert, active-low reset.
- cfg_dly  input  CNT_W  spacing value D; each hold/release step lasts D+1 cycles.
- cfg_mask  input  NUM_RST  1 = channel takes part in the sequence; 0 = channel held in reset permanently.
- soft_req  input  1  software request to re-run the sequence.
- soft_ack  output  1  one-cycle acknowledge of an accepted soft_req.
- rst_out  output  NUM_RST  per-domain reset, active-low, registered.
- busy  output  1  high in HOLD and RELEASE.
- done  output  1  high in DONE.

Behaviour:
- Reset:
  - rst=0 asynchronously clears the synchroniser, FSM (RESET), counter, index and all outputs.
  - Output values during reset: rst_out=0 (all domains asserted), soft_ack=0, busy=0, done=0.
- Synchroniser:
  - On rst deassertion, the synchronised reset goes high after SYNC_STAGES rising edges.
  - The FSM leaves RESET on the following edge, i.e. it enters HOLD on edge SYNC_STAGES+1.
- Config latching: cfg_dly and cfg_mask are latched on every entry to HOLD. Changes later in the sequence have no effect.
- Counter: cnt is loaded with D on entry to HOLD and after each event. Each cycle it decrements if non-zero. cnt==0 marks an event.
- HOLD:
  - Event -> RELEASE; cnt reloads; idx = lowest enabled channel.
  - If the mask is all-zero -> DONE instead; all rst_out stay 0.
- RELEASE:
  - Event -> rst_out[idx]<=1; idx advances to the next enabled channel, skipping masked channels in zero cycles; cnt reloads.
  - If idx was the highest enabled channel -> DONE on the same edge.
- DONE: holds rst_out. soft_req=1 triggers, on the next edge:
  - all rst_out<=0;
  - soft_ack<=1 for exactly one cycle;
  - FSM -> HOLD.
- soft_req in RESET/HOLD/RELEASE is ignored and soft_ack stays 0. soft_req held high in DONE restarts the sequence once per DONE visit.
- Timing: first release occurs 2(D+1) cycles after HOLD entry; subsequent releases every D+1 cycles. D=0 releases one channel per cycle.
- rst reasserted mid-sequence: immediate asynchronous return to the reset values above. The sequence restarts from scratch after deassertion.
- Masked channels never deassert. Output bits at or above NUM_RST do not exist.

Optional Feature:
- Macro: RST_SEQ_CLKEN_EN.
- With the macro defined:
  - An extra output clk_en[NUM_RST] exists; reset value 0.
  - clk_en[i] goes 1 on the edge where channel i becomes the current idx in RELEASE, so it leads rst_out[i] by D+1 cycles.
  - It stays 1 until rst or a soft restart clears it.
  - Masked channels keep clk_en=0.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- NUM_RST=4, D=2, mask=4'b1111, rst released: HOLD at edge 3 (T) -> rst_out[0..3] rise at T+6, T+9, T+12, T+15; done=1 and busy=0 from T+15.
- D=0, mask=4'b1010: rst_out[1] rises at T+2, rst_out[3] at T+3 with done; rst_out[0] and rst_out[2] stay 0 throughout.
- mask=0, D=5: DONE at T+6; rst_out=0 throughout; busy high for exactly 6 cycles.
- In DONE, pulse soft_req: next edge rst_out=0 and soft_ack=1 for one cycle; sequence repeats the first scenario's timing from the new HOLD entry. soft_req during RELEASE: no ack and no effect.
- rst pulsed low between the 2nd and 3rd release: rst_out, busy and done clear immediately (asynchronously); the full sequence restarts after deassertion.
- With RST_SEQ_CLKEN_EN, first scenario's settings: clk_en[0] rises at T+3, clk_en[1] at T+6, clk_en[3] at T+12; all clear on a soft restart.

Source files
------------

// File: rtl/rst_release_seq.sv
// Reset release sequencer: synchronises reset deassertion, holds all domains, then releases them one by one.
// Optional macro RST_SEQ_CLKEN_EN adds a per-domain clk_en output that leads each release by one step.
module rst_release_seq #(
    parameter int NUM_RST     = 32,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   cfg_dly,
    input  logic [NUM_RST-1:0] cfg_mask,
    input  logic               soft_req,
    output logic               soft_ack,
    output logic [NUM_RST-1:0] rst_out,
    output logic               busy,
    output logic               done
`ifdef RST_SEQ_CLKEN_EN
    ,
    output logic [NUM_RST-1:0] clk_en
`endif
);

    localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

    typedef enum logic [1:0] {
        S_RESET,
        S_HOLD,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               w_rst_sync;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_dly;
    logic [NUM_RST-1:0] r_mask;
    logic [IDX_W-1:0]   r_idx;
    logic [NUM_RST-1:0] r_rst_out;
    logic               r_soft_ack;
    logic [IDX_W-1:0]   w_first_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_has_next;
    logic               w_any_en;
    logic               w_event;
    logic               w_enter_hold;
    logic               w_soft_restart;
    logic               w_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rst_sync = r_sync[SYNC_STAGES-1];

    // Lowest enabled channel overall, and lowest enabled channel above the current index.
    always_comb begin
        w_first_idx = '0;
        w_next_idx  = '0;
        w_has_next  = 1'b0;
        for (int i = NUM_RST - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_first_idx = IDX_W'(i);
                if (IDX_W'(i) > r_idx) begin
                    w_next_idx = IDX_W'(i);
                    w_has_next = 1'b1;
                end
            end
        end
    end

    assign w_any_en       = |r_mask;
    assign w_event        = (r_cnt == '0);
    assign w_active       = (r_state == S_HOLD) || (r_state == S_RELEASE);
    assign w_soft_restart = (r_state == S_DONE) && soft_req;
    assign w_enter_hold   = (w_next_state == S_HOLD) && (r_state != S_HOLD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET: begin
                if (w_rst_sync) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_event) begin
                    w_next_state = w_any_en ? S_RELEASE : S_DONE;
                end
            end
            S_RELEASE: begin
                if (w_event && !w_has_next) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (soft_req) begin
                    w_next_state = S_HOLD;
                end
            end
            default: w_next_state = S_RESET;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_HOLD:    busy = 1'b1;
            S_RELEASE: busy = 1'b1;
            S_DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Configuration is frozen at each HOLD entry so mid-sequence edits cannot disturb the release order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dly  <= '0;
            r_mask <= '0;
            r_cnt  <= '0;
        end else if (w_enter_hold) begin
            r_dly  <= cfg_dly;
            r_mask <= cfg_mask;
            r_cnt  <= cfg_dly;
        end else if (w_active) begin
            if (w_event) begin
                r_cnt <= r_dly;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
        end else if ((r_state == S_HOLD) && w_event) begin
            r_idx <= w_first_idx;
        end else if ((r_state == S_RELEASE) && w_event && w_has_next) begin
            r_idx <= w_next_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_out  <= '0;
            r_soft_ack <= 1'b0;
        end else begin
            r_soft_ack <= w_soft_restart;
            if (w_soft_restart) begin
                r_rst_out <= '0;
            end else if ((r_state == S_RELEASE) && w_event) begin
                r_rst_out[r_idx] <= 1'b1;
            end
        end
    end

    assign rst_out  = r_rst_out;
    assign soft_ack = r_soft_ack;

`ifdef RST_SEQ_CLKEN_EN
    logic [NUM_RST-1:0] r_clk_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_en <= '0;
        end else if (w_soft_restart) begin
            r_clk_en <= '0;
        end else if ((r_state == S_HOLD) && w_event && w_any_en) begin
            r_clk_en[w_first_idx] <= 1'b1;
        end else if ((r_state == S_RELEASE) && w_event && w_has_next) begin
            r_clk_en[w_next_idx] <= 1'b1;
        end
    end

    assign clk_en = r_clk_en;
`endif

endmodule

// File: tb/tb_rst_release_seq.sv
// Self-checking bench for rst_release_seq (NUM_RST=4); covers clk_en when RST_SEQ_CLKEN_EN is defined.
module tb_rst_release_seq;

    localparam int N  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg_dly;
    logic [N-1:0]  cfg_mask;
    logic          soft_req;
    logic          soft_ack;
    logic [N-1:0]  rst_out;
    logic          busy;
    logic          done;
`ifdef RST_SEQ_CLKEN_EN
    logic [N-1:0]  clk_en;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [CW-1:0] dly;
        logic [N-1:0]  mask;
        int            off;
        logic [N-1:0]  eRst;
        logic          eBusy;
        logic          eDone;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rst_release_seq #(
        .NUM_RST(N),
        .CNT_W(CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_dly(cfg_dly),
        .cfg_mask(cfg_mask),
        .soft_req(soft_req),
        .soft_ack(soft_ack),
        .rst_out(rst_out),
        .busy(busy),
        .done(done)
`ifdef RST_SEQ_CLKEN_EN
        ,
        .clk_en(clk_en)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [N-1:0] eRst, input logic eBusy, input logic eDone);
        checkOutput({tag, " rst_out"}, 32'(rst_out), 32'(eRst));
        checkOutput({tag, " busy"}, 32'(busy), 32'(eBusy));
        checkOutput({tag, " done"}, 32'(done), 32'(eDone));
    endtask

    // Full reset, release on a falling edge, return at the falling edge just after HOLD entry (edge 3).
    task automatic applyStimulus(input logic [CW-1:0] dly, input logic [N-1:0] mask);
        @(negedge clk);
        rst      = 1'b0;
        cfg_dly  = dly;
        cfg_mask = mask;
        soft_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic addVec(input logic [CW-1:0] dly, input logic [N-1:0] mask, input int off,
                          input logic [N-1:0] eRst, input logic eBusy, input logic eDone);
        vec_t v;
        v.dly   = dly;
        v.mask  = mask;
        v.off   = off;
        v.eRst  = eRst;
        v.eBusy = eBusy;
        v.eDone = eDone;
        vecs.push_back(v);
    endtask

    initial begin
        int curOff;

        rst      = 1'b0;
        cfg_dly  = 16'd2;
        cfg_mask = 4'b1111;
        soft_req = 1'b0;
        #12;
        checkState("reset", 4'b0000, 1'b0, 1'b0);
        checkOutput("reset soft_ack", 32'(soft_ack), 32'd0);

        addVec(16'd2, 4'b1111,  0, 4'b0000, 1'b1, 1'b0);
        addVec(16'd2, 4'b1111,  5, 4'b0000, 1'b1, 1'b0);
        addVec(16'd2, 4'b1111,  6, 4'b0001, 1'b1, 1'b0);
        addVec(16'd2, 4'b1111,  8, 4'b0001, 1'b1, 1'b0);
        addVec(16'd2, 4'b1111,  9, 4'b0011, 1'b1, 1'b0);
        addVec(16'd2, 4'b1111, 12, 4'b0111, 1'b1, 1'b0);
        addVec(16'd2, 4'b1111, 14, 4'b0111, 1'b1, 1'b0);
        addVec(16'd2, 4'b1111, 15, 4'b1111, 1'b0, 1'b1);
        addVec(16'd2, 4'b1111, 20, 4'b1111, 1'b0, 1'b1);
        addVec(16'd0, 4'b1010,  0, 4'b0000, 1'b1, 1'b0);
        addVec(16'd0, 4'b1010,  1, 4'b0000, 1'b1, 1'b0);
        addVec(16'd0, 4'b1010,  2, 4'b0010, 1'b1, 1'b0);
        addVec(16'd0, 4'b1010,  3, 4'b1010, 1'b0, 1'b1);
        addVec(16'd0, 4'b1010,  6, 4'b1010, 1'b0, 1'b1);
        addVec(16'd5, 4'b0000,  0, 4'b0000, 1'b1, 1'b0);
        addVec(16'd5, 4'b0000,  5, 4'b0000, 1'b1, 1'b0);
        addVec(16'd5, 4'b0000,  6, 4'b0000, 1'b0, 1'b1);
        addVec(16'd5, 4'b0000, 10, 4'b0000, 1'b0, 1'b1);

        curOff = 0;
        for (int k = 0; k < vecs.size(); k++) begin
            if (vecs[k].off == 0) begin
                applyStimulus(vecs[k].dly, vecs[k].mask);
                curOff = 0;
            end else begin
                repeat (vecs[k].off - curOff) @(negedge clk);
                curOff = vecs[k].off;
            end
            checkState($sformatf("vec%0d off%0d", k, vecs[k].off), vecs[k].eRst, vecs[k].eBusy, vecs[k].eDone);
        end

        // Soft restart from DONE, config edits after HOLD entry, and soft_req during RELEASE.
        applyStimulus(16'd2, 4'b1111);
        repeat (16) @(negedge clk);
        checkState("soft pre", 4'b1111, 1'b0, 1'b1);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;
        cfg_dly  = 16'd7;
        cfg_mask = 4'b0001;
        checkState("soft S", 4'b0000, 1'b1, 1'b0);
        checkOutput("soft S ack", 32'(soft_ack), 32'd1);
        @(negedge clk);
        checkOutput("soft S+1 ack", 32'(soft_ack), 32'd0);
        repeat (4) @(negedge clk);
        checkState("soft S+5", 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkState("soft S+6", 4'b0001, 1'b1, 1'b0);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;
        checkOutput("release req ack", 32'(soft_ack), 32'd0);
        checkState("soft S+7", 4'b0001, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checkState("soft S+9", 4'b0011, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        checkState("soft S+15", 4'b1111, 1'b0, 1'b1);

        // Held soft_req restarts only once per DONE visit.
        soft_req = 1'b1;
        @(negedge clk);
        checkOutput("held req ack", 32'(soft_ack), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("held req ack later", 32'(soft_ack), 32'd0);
        checkState("held req busy", 4'b0000, 1'b1, 1'b0);
        soft_req = 1'b0;

        // Asynchronous reset between the 2nd and 3rd release, then a full restart.
        applyStimulus(16'd2, 4'b1111);
        repeat (10) @(negedge clk);
        checkState("midrst before", 4'b0011, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        checkState("midrst async", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkState("midrst sync1", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkState("midrst sync2", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checkState("midrst T", 4'b0000, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checkState("midrst T+5", 4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checkState("midrst T+6", 4'b0001, 1'b1, 1'b0);

`ifdef RST_SEQ_CLKEN_EN
        applyStimulus(16'd2, 4'b1111);
        checkOutput("clken T", 32'(clk_en), 32'h0);
        repeat (2) @(negedge clk);
        checkOutput("clken T+2", 32'(clk_en), 32'h0);
        @(negedge clk);
        checkOutput("clken T+3", 32'(clk_en), 32'h1);
        repeat (3) @(negedge clk);
        checkOutput("clken T+6", 32'(clk_en), 32'h3);
        repeat (5) @(negedge clk);
        checkOutput("clken T+11", 32'(clk_en), 32'h7);
        @(negedge clk);
        checkOutput("clken T+12", 32'(clk_en), 32'hF);
        repeat (4) @(negedge clk);
        checkOutput("clken done", 32'(clk_en), 32'hF);
        soft_req = 1'b1;
        @(negedge clk);
        soft_req = 1'b0;
        checkOutput("clken soft clear", 32'(clk_en), 32'h0);

        applyStimulus(16'd0, 4'b1010);
        @(negedge clk);
        checkOutput("clken mask T+1", 32'(clk_en), 32'h2);
        @(negedge clk);
        checkOutput("clken mask T+2", 32'(clk_en), 32'hA);
        repeat (3) @(negedge clk);
        checkOutput("clken mask T+5", 32'(clk_en), 32'hA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
